// File: rtl/seq_muldiv_unit.sv
// ---------------------------------------------------------------------------
// seq_muldiv_unit
//   Iterative multiply/divide unit with HI/LO result registers. It sits
//   beside the EX-stage ALU. It runs MULT/MULTU with radix-2 shift-add and
//   DIV/DIVU with restoring shift-subtract, one bit per cycle, then applies
//   sign correction for one cycle.
//
// Ports
//   clk      rising-edge clock
//   reset    asynchronous, active-low reset
//   Start    begin operation (sampled only in IDLE)
//   Op       00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   A, B     operands, captured on the Start edge
//   Abort    flush an in-flight operation (no Done, HI/LO untouched)
//   HiWe     MTHI write strobe (IDLE only)
//   LoWe     MTLO write strobe (IDLE only)
//   WData    MTHI/MTLO data
//   Busy     high while in CALC or FIX
//   Done     one-cycle pulse; HI/LO already hold the new result
//   DivZero  sticky: last completed divide had B==0; cleared by Start
//   HI, LO   result registers (high product/remainder, low product/quotient)
// ---------------------------------------------------------------------------
module seq_muldiv_unit #(
   parameter int unsigned W     = 32,
   parameter int unsigned CNT_W = 6
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         Start,
   input  logic [1:0]   Op,
   input  logic [W-1:0] A,
   input  logic [W-1:0] B,
   input  logic         Abort,
   input  logic         HiWe,
   input  logic         LoWe,
   input  logic [W-1:0] WData,
   output logic         Busy,
   output logic         Done,
   output logic         DivZero,
   output logic [W-1:0] HI,
   output logic [W-1:0] LO
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             is_div_q, is_div_d;
   logic             sign_a_q, sign_a_d;
   logic             sign_b_q, sign_b_d;
   logic             dz_q, dz_d;
   logic [2*W-1:0]   acc_q, acc_d;
   logic [W-1:0]     opnd_q, opnd_d;
   logic [W-1:0]     hi_q, hi_d;
   logic [W-1:0]     lo_q, lo_d;
   logic             div_zero_q, div_zero_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   // Operand conditioning at Start
   logic         op_signed;
   logic         a_neg, b_neg;
   logic [W-1:0] a_mag, b_mag;
   logic         start_dz;

   // Iteration datapath
   logic [W:0]     mult_sum;
   logic [2*W-1:0] mult_next;
   logic [W:0]     div_trial;
   logic [W:0]     div_diff;
   logic [2*W-1:0] div_next;

   // Sign correction
   logic [2*W-1:0] prod_fix;
   logic [W-1:0]   quot_fix;
   logic [W-1:0]   rem_fix;
   logic [W-1:0]   res_hi, res_lo;

   always_comb begin
      op_signed = ~Op[0];
      a_neg     = op_signed & A[W-1];
      b_neg     = op_signed & B[W-1];
      a_mag     = a_neg ? -A : A;
      b_mag     = b_neg ? -B : B;
      start_dz  = Op[1] & (B == '0);
   end

   // acc holds {upper, lower}: for multiply {partial product, remaining
   // multiplier bits}; for divide {partial remainder, dividend/quotient bits}.
   always_comb begin
      mult_sum  = {1'b0, acc_q[2*W-1:W]} + {1'b0, opnd_q};
      mult_next = acc_q[0] ? {mult_sum, acc_q[W-1:1]}
                           : {1'b0, acc_q[2*W-1:1]};

      // Remainder stays below the divisor, so the shifted trial fits W+1 bits
      // and a non-negative difference always fits back into W bits.
      div_trial = {acc_q[2*W-1:W], acc_q[W-1]};
      div_diff  = div_trial - {1'b0, opnd_q};
      div_next  = div_diff[W] ? {div_trial[W-1:0], acc_q[W-2:0], 1'b0}
                              : {div_diff[W-1:0],  acc_q[W-2:0], 1'b1};
   end

   // Divide-by-zero loads acc with {|A|, all ones}; the remainder sign fix
   // then restores A itself and the quotient is left uncorrected.
   always_comb begin
      prod_fix = (sign_a_q ^ sign_b_q) ? -acc_q : acc_q;
      quot_fix = ((sign_a_q ^ sign_b_q) && !dz_q) ? -acc_q[W-1:0]
                                                 : acc_q[W-1:0];
      rem_fix  = sign_a_q ? -acc_q[2*W-1:W] : acc_q[2*W-1:W];
      res_hi   = is_div_q ? rem_fix  : prod_fix[2*W-1:W];
      res_lo   = is_div_q ? quot_fix : prod_fix[W-1:0];
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      is_div_d   = is_div_q;
      sign_a_d   = sign_a_q;
      sign_b_d   = sign_b_q;
      dz_d       = dz_q;
      acc_d      = acc_q;
      opnd_d     = opnd_q;
      hi_d       = hi_q;
      lo_d       = lo_q;
      div_zero_d = div_zero_q;

      case (state_q)
         IDLE: begin
            if (HiWe) hi_d = WData;
            if (LoWe) lo_d = WData;
            if (Start) begin
               cnt_d      = CNT_W'(W - 1);
               is_div_d   = Op[1];
               sign_a_d   = a_neg;
               sign_b_d   = b_neg;
               opnd_d     = b_mag;
               dz_d       = start_dz;
               div_zero_d = 1'b0;
               if (start_dz) begin
                  acc_d   = {a_mag, {W{1'b1}}};
                  state_d = FIX;
               end else begin
                  acc_d   = {{W{1'b0}}, a_mag};
                  state_d = CALC;
               end
            end
         end
         CALC: begin
            if (Abort) begin
               state_d = IDLE;
            end else begin
               acc_d = is_div_q ? div_next : mult_next;
               if (cnt_q == '0) begin
                  state_d = FIX;
               end else begin
                  cnt_d = cnt_q - CNT_W'(1);
               end
            end
         end
         FIX: begin
            if (Abort) begin
               state_d = IDLE;
            end else begin
               hi_d       = res_hi;
               lo_d       = res_lo;
               div_zero_d = dz_q;
               state_d    = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d = (state_d == CALC) || (state_d == FIX);
      done_d = (state_d == DONE);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         is_div_q   <= 1'b0;
         sign_a_q   <= 1'b0;
         sign_b_q   <= 1'b0;
         dz_q       <= 1'b0;
         acc_q      <= '0;
         opnd_q     <= '0;
         hi_q       <= '0;
         lo_q       <= '0;
         div_zero_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         is_div_q   <= is_div_d;
         sign_a_q   <= sign_a_d;
         sign_b_q   <= sign_b_d;
         dz_q       <= dz_d;
         acc_q      <= acc_d;
         opnd_q     <= opnd_d;
         hi_q       <= hi_d;
         lo_q       <= lo_d;
         div_zero_q <= div_zero_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   assign Busy    = busy_q;
   assign Done    = done_q;
   assign DivZero = div_zero_q;
   assign HI      = hi_q;
   assign LO      = lo_q;

endmodule

// File: tb/tb_seq_muldiv_unit.sv
// ---------------------------------------------------------------------------
// tb_seq_muldiv_unit
//   Directed bench for seq_muldiv_unit (W=32): multiply/divide results,
//   latency, divide-by-zero, Start-while-busy, Abort, mid-op reset and
//   HI/LO write strobes. Expected values are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_seq_muldiv_unit;
   localparam int unsigned W = 32;
   localparam int LAT_NORM = W + 2;
   localparam int LAT_DZ   = 2;

   logic         clk = 1'b0;
   logic         reset;
   logic         Start;
   logic [1:0]   Op;
   logic [W-1:0] A;
   logic [W-1:0] B;
   logic         Abort;
   logic         HiWe;
   logic         LoWe;
   logic [W-1:0] WData;
   logic         Busy;
   logic         Done;
   logic         DivZero;
   logic [W-1:0] HI;
   logic [W-1:0] LO;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   seq_muldiv_unit #(.W(W), .CNT_W(6)) dut (
      .clk     (clk),
      .reset   (reset),
      .Start   (Start),
      .Op      (Op),
      .A       (A),
      .B       (B),
      .Abort   (Abort),
      .HiWe    (HiWe),
      .LoWe    (LoWe),
      .WData   (WData),
      .Busy    (Busy),
      .Done    (Done),
      .DivZero (DivZero),
      .HI      (HI),
      .LO      (LO)
   );

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", name, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      Op    = op;
      A     = a;
      B     = b;
      Start = 1'b1;
      tick();
      Start = 1'b0;
   endtask

   // n = cycle index relative to the Start edge (first cycle after it is 1)
   task automatic wait_done(output int n, output int busy_cycles);
      n = 1;
      busy_cycles = 0;
      while (Done !== 1'b1 && n < 100) begin
         if (Busy === 1'b1) busy_cycles++;
         tick();
         n++;
      end
   endtask

   task automatic run_op(input string tag, input logic [1:0] op,
                         input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo,
                         input int exp_n, input logic exp_dz, output int bc);
      int n;
      start_op(op, a, b);
      wait_done(n, bc);
      chk({tag, "_latency"}, 64'(n), 64'(exp_n));
      chk({tag, "_hi"}, 64'(HI), 64'(exp_hi));
      chk({tag, "_lo"}, 64'(LO), 64'(exp_lo));
      chk({tag, "_divzero"}, 64'(DivZero), 64'(exp_dz));
      tick();
      chk({tag, "_done_pulse"}, 64'({Busy, Done}), 64'(0));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected end of test");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n;
      int bc;
      logic saw;

      reset = 1'b0; Start = 1'b0; Op = 2'b00; A = '0; B = '0;
      Abort = 1'b0; HiWe = 1'b0; LoWe = 1'b0; WData = '0;
      tick();
      tick();
      chk("reset_hi", 64'(HI), 64'(0));
      chk("reset_lo", 64'(LO), 64'(0));
      chk("reset_busy", 64'(Busy), 64'(0));
      chk("reset_done", 64'(Done), 64'(0));
      chk("reset_divzero", 64'(DivZero), 64'(0));
      reset = 1'b1;
      tick();

      run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
             32'hFFFF_FFFE, 32'h0000_0001, LAT_NORM, 1'b0, bc);
      chk("multu_max_busy_cycles", 64'(bc), 64'(33));

      run_op("mult_neg", 2'b00, 32'hFFFF_FFFD, 32'd5,
             32'hFFFF_FFFF, 32'hFFFF_FFF1, LAT_NORM, 1'b0, bc);
      run_op("mult_min_sq", 2'b00, 32'h8000_0000, 32'h8000_0000,
             32'h4000_0000, 32'h0000_0000, LAT_NORM, 1'b0, bc);
      run_op("div_neg_dividend", 2'b10, 32'hFFFF_FFF9, 32'd2,
             32'hFFFF_FFFF, 32'hFFFF_FFFD, LAT_NORM, 1'b0, bc);
      run_op("div_min_by_m1", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF,
             32'h0000_0000, 32'h8000_0000, LAT_NORM, 1'b0, bc);
      run_op("div_neg_divisor", 2'b10, 32'd7, 32'hFFFF_FFFE,
             32'h0000_0001, 32'hFFFF_FFFD, LAT_NORM, 1'b0, bc);
      run_op("divu", 2'b11, 32'd100, 32'd7,
             32'd2, 32'd14, LAT_NORM, 1'b0, bc);
      run_op("divu_zero", 2'b11, 32'd7, 32'd0,
             32'd7, 32'hFFFF_FFFF, LAT_DZ, 1'b1, bc);

      // DivZero clears on the next Start edge
      start_op(2'b01, 32'd3, 32'd4);
      chk("divzero_cleared", 64'(DivZero), 64'(0));
      wait_done(n, bc);
      chk("multu_small_hi", 64'(HI), 64'(0));
      chk("multu_small_lo", 64'(LO), 64'(12));
      tick();

      run_op("div_zero_signed", 2'b10, 32'hFFFF_FFFB, 32'd0,
             32'hFFFF_FFFB, 32'hFFFF_FFFF, LAT_DZ, 1'b1, bc);

      // Start while busy is ignored
      start_op(2'b01, 32'd2, 32'd3);
      chk("busy_start_divzero_clr", 64'(DivZero), 64'(0));
      repeat (4) tick();
      Op = 2'b11; A = 32'd100; B = 32'd7; Start = 1'b1;
      tick();
      Start = 1'b0;
      wait_done(n, bc);
      chk("busy_start_latency", 64'(n + 5), 64'(LAT_NORM));
      chk("busy_start_hi", 64'(HI), 64'(0));
      chk("busy_start_lo", 64'(LO), 64'(6));
      tick();

      // Abort sampled at edge t+10, with a Start that must be ignored
      start_op(2'b00, 32'd6, 32'd7);
      repeat (9) tick();
      chk("abort_pre_busy", 64'(Busy), 64'(1));
      Abort = 1'b1; Start = 1'b1; Op = 2'b01; A = 32'd9; B = 32'd9;
      tick();
      Abort = 1'b0; Start = 1'b0;
      chk("abort_busy", 64'(Busy), 64'(0));
      chk("abort_done", 64'(Done), 64'(0));
      saw = 1'b0;
      repeat (40) begin
         tick();
         if (Busy === 1'b1 || Done === 1'b1) saw = 1'b1;
      end
      chk("abort_no_activity", 64'(saw), 64'(0));
      chk("abort_hi_kept", 64'(HI), 64'(0));
      chk("abort_lo_kept", 64'(LO), 64'(6));

      // Reset asserted mid-divide acts immediately
      start_op(2'b10, 32'd100, 32'd7);
      repeat (4) tick();
      chk("rst_mid_pre_busy", 64'(Busy), 64'(1));
      reset = 1'b0;
      #1;
      chk("rst_mid_hi", 64'(HI), 64'(0));
      chk("rst_mid_lo", 64'(LO), 64'(0));
      chk("rst_mid_busy", 64'(Busy), 64'(0));
      #1;
      reset = 1'b1;
      saw = 1'b0;
      repeat (40) begin
         tick();
         if (Busy === 1'b1 || Done === 1'b1) saw = 1'b1;
      end
      chk("rst_mid_no_done", 64'(saw), 64'(0));

      // HiWe alongside Start lands, then the product overwrites it
      HiWe = 1'b1; WData = 32'hDEAD_BEEF;
      Op = 2'b01; A = 32'h0001_0000; B = 32'h0001_0000; Start = 1'b1;
      tick();
      Start = 1'b0; HiWe = 1'b0;
      chk("hiwe_start_hi", 64'(HI), 64'(32'hDEAD_BEEF));
      chk("hiwe_start_busy", 64'(Busy), 64'(1));
      LoWe = 1'b1; WData = 32'h1234_5678;
      tick();
      LoWe = 1'b0;
      chk("lowe_busy_ignored", 64'(LO), 64'(0));
      wait_done(n, bc);
      chk("hiwe_op_latency", 64'(n + 1), 64'(LAT_NORM));
      chk("hiwe_op_hi", 64'(HI), 64'(1));
      chk("hiwe_op_lo", 64'(LO), 64'(0));
      HiWe = 1'b1; WData = 32'h0000_0055;
      tick();
      HiWe = 1'b0;
      chk("hiwe_done_ignored", 64'(HI), 64'(1));
      HiWe = 1'b1; LoWe = 1'b1; WData = 32'hA5A5_A5A5;
      tick();
      HiWe = 1'b0; LoWe = 1'b0;
      chk("mthi_mtlo_hi", 64'(HI), 64'(32'hA5A5_A5A5));
      chk("mthi_mtlo_lo", 64'(LO), 64'(32'hA5A5_A5A5));

      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end
endmodule
